// File: rtl/dec_hzrd_scbd_pkg.sv
// Shared types and helpers for the decode-stage hazard/forwarding scoreboard.
// Holds the per-stage entry layout and the forward-select encoding.
package dec_pkg;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       wen;
      logic       load;
   } scbd_entry_t;

   localparam int          FWD_SEL_RF = 0;
   localparam scbd_entry_t SCBD_EMPTY = '{vld: 1'b0, rd: 5'd0, wen: 1'b0, load: 1'b0};

   function automatic int fwd_sel_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dec_hzrd_scbd_if.sv
// ID-stage request and hazard/forwarding response bundle of the scoreboard.
// master drives the decoded instruction, slave (the scoreboard) answers.
interface dec_hzrd_scbd_if
   import dec_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = 32
);
   localparam int SEL_W = fwd_sel_w(NUM_STAGES);

   logic             i_id_vld;
   logic [4:0]       i_id_rs1_raddr;
   logic [4:0]       i_id_rs2_raddr;
   logic             i_id_rs1_use;
   logic             i_id_rs2_use;
   logic [4:0]       i_id_rd_waddr;
   logic             i_id_rd_wen;
   logic             i_id_load;
   logic             i_flush;
   logic             i_stall;
   logic             o_hold;
   logic             o_bubble;
   logic [SEL_W-1:0] o_fwd_sel_op1;
   logic [SEL_W-1:0] o_fwd_sel_op2;
   logic [CNT_W-1:0] o_stall_cnt;

   modport master (
      output i_id_vld, i_id_rs1_raddr, i_id_rs2_raddr, i_id_rs1_use, i_id_rs2_use,
      output i_id_rd_waddr, i_id_rd_wen, i_id_load, i_flush, i_stall,
      input  o_hold, o_bubble, o_fwd_sel_op1, o_fwd_sel_op2, o_stall_cnt
   );

   modport slave (
      input  i_id_vld, i_id_rs1_raddr, i_id_rs2_raddr, i_id_rs1_use, i_id_rs2_use,
      input  i_id_rd_waddr, i_id_rd_wen, i_id_load, i_flush, i_stall,
      output o_hold, o_bubble, o_fwd_sel_op1, o_fwd_sel_op2, o_stall_cnt
   );

endinterface

// File: rtl/dec_hzrd_scbd_match.sv
// Per-operand lookup: finds the youngest in-flight writer of raddr and
// resolves it into a forward select or a load-use hazard.
module dec_hzrd_match
   import dec_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_STAGE = 2,
   parameter int RF_BYPASS  = 1,
   parameter int SEL_W      = fwd_sel_w(NUM_STAGES)
) (
   input  scbd_entry_t [NUM_STAGES:1] ents_i,
   input  logic [4:0]                 raddr_i,
   input  logic                       use_i,
   input  logic                       vld_i,
   output logic [SEL_W-1:0]           sel_o,
   output logic                       hazard_o
);

   logic qual_s;
   logic hit_s;
   logic hit_load_s;
   int   hit_k_s;

   assign qual_s = vld_i & use_i & (raddr_i != 5'd0);

   // Youngest-writer search: scanning oldest to youngest lets the smallest k win.
   always_comb begin
      hit_s      = 1'b0;
      hit_load_s = 1'b0;
      hit_k_s    = 0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (qual_s && ents_i[k].vld && ents_i[k].wen && (ents_i[k].rd == raddr_i)) begin
            hit_s      = 1'b1;
            hit_load_s = ents_i[k].load;
            hit_k_s    = k;
         end else begin
            hit_s      = hit_s;
            hit_load_s = hit_load_s;
            hit_k_s    = hit_k_s;
         end
      end
   end

   // Resolve the hit: load data not ready yet stalls, the WB stage may come from the RF.
   always_comb begin
      sel_o    = SEL_W'(FWD_SEL_RF);
      hazard_o = 1'b0;
      if (!hit_s) begin
         sel_o = SEL_W'(FWD_SEL_RF);
      end else if (hit_load_s && (hit_k_s < LOAD_STAGE)) begin
         hazard_o = 1'b1;
      end else if ((RF_BYPASS != 0) && (hit_k_s == NUM_STAGES)) begin
         sel_o = SEL_W'(FWD_SEL_RF);
      end else begin
         sel_o = SEL_W'(hit_k_s);
      end
   end

endmodule

// File: rtl/dec_hzrd_scbd.sv
// Decode-stage hazard/forwarding scoreboard: a shift register of in-flight
// destinations, two operand matchers, hold/bubble generation and a stall counter.
module dec_hzrd_scbd
   import dec_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_STAGE = 2,
   parameter int RF_BYPASS  = 1,
   parameter int CNT_W      = 32
) (
   input logic             i_clk,
   input logic             i_rst,
   dec_hzrd_scbd_if.slave  bus
);

   localparam int             SEL_W   = fwd_sel_w(NUM_STAGES);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   scbd_entry_t [NUM_STAGES:1] ents_q, ents_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   scbd_entry_t                id_ent_s;
   logic [SEL_W-1:0]           sel1_s, sel2_s;
   logic                       haz1_s, haz2_s;
   logic                       hazard_s, hold_s, bubble_s;

   assign id_ent_s = '{vld: 1'b1, rd: bus.i_id_rd_waddr, wen: bus.i_id_rd_wen, load: bus.i_id_load};

   dec_hzrd_match #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .RF_BYPASS  (RF_BYPASS),
      .SEL_W      (SEL_W)
   ) u_match_op1 (
      .ents_i   (ents_q),
      .raddr_i  (bus.i_id_rs1_raddr),
      .use_i    (bus.i_id_rs1_use),
      .vld_i    (bus.i_id_vld),
      .sel_o    (sel1_s),
      .hazard_o (haz1_s)
   );

   dec_hzrd_match #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .RF_BYPASS  (RF_BYPASS),
      .SEL_W      (SEL_W)
   ) u_match_op2 (
      .ents_i   (ents_q),
      .raddr_i  (bus.i_id_rs2_raddr),
      .use_i    (bus.i_id_rs2_use),
      .vld_i    (bus.i_id_vld),
      .sel_o    (sel2_s),
      .hazard_o (haz2_s)
   );

   // Flush squashes the ID instruction, so it also cancels its hazard.
   assign hazard_s = (haz1_s | haz2_s) & ~bus.i_flush;
   assign hold_s   = bus.i_stall | hazard_s;
   assign bubble_s = hazard_s & ~bus.i_stall;

   assign bus.o_hold        = hold_s;
   assign bus.o_bubble      = bubble_s;
   assign bus.o_fwd_sel_op1 = sel1_s;
   assign bus.o_fwd_sel_op2 = sel2_s;
   assign bus.o_stall_cnt   = cnt_q;

   // Next state: shift the pipeline shadow unless frozen, count bubbles with saturation.
   always_comb begin
      ents_d = ents_q;
      cnt_d  = cnt_q;
      if (!bus.i_stall) begin
         for (int k = NUM_STAGES; k >= 2; k--) begin
            ents_d[k] = ents_q[k-1];
         end
         if (bus.i_id_vld && !hold_s && !bus.i_flush) begin
            ents_d[1] = id_ent_s;
         end else begin
            ents_d[1] = SCBD_EMPTY;
         end
      end else begin
         ents_d = ents_q;
      end
      if (bubble_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ents_q <= '0;
         cnt_q  <= '0;
      end else begin
         ents_q <= ents_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dec_hzrd_scbd.sv
// Directed bench: default scoreboard (A) plus a 4-stage, late-load, no-bypass,
// 2-bit-counter variant (B) for the non-default forwarding and saturation cases.
module tb_dec_hzrd_scbd;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   dec_hzrd_scbd_if #(.NUM_STAGES(3), .CNT_W(32)) a_if ();
   dec_hzrd_scbd_if #(.NUM_STAGES(4), .CNT_W(2))  b_if ();

   dec_hzrd_scbd #(.NUM_STAGES(3), .LOAD_STAGE(2), .RF_BYPASS(1), .CNT_W(32)) u_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (a_if.slave)
   );

   dec_hzrd_scbd #(.NUM_STAGES(4), .LOAD_STAGE(3), .RF_BYPASS(0), .CNT_W(2)) u_b (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (b_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic vld, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic ld);
      a_if.i_id_vld = vld;       a_if.i_id_rs1_raddr = rs1; a_if.i_id_rs1_use = u1;
      a_if.i_id_rs2_raddr = rs2; a_if.i_id_rs2_use = u2;    a_if.i_id_rd_waddr = rd;
      a_if.i_id_rd_wen = wen;    a_if.i_id_load = ld;
      #1;
   endtask

   task automatic drive_b(input logic vld, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic ld);
      b_if.i_id_vld = vld;       b_if.i_id_rs1_raddr = rs1; b_if.i_id_rs1_use = u1;
      b_if.i_id_rs2_raddr = rs2; b_if.i_id_rs2_use = u2;    b_if.i_id_rd_waddr = rd;
      b_if.i_id_rd_wen = wen;    b_if.i_id_load = ld;
      #1;
   endtask

   initial begin
      a_if.i_flush = 1'b0; a_if.i_stall = 1'b0;
      b_if.i_flush = 1'b0; b_if.i_stall = 1'b0;
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #10;
      chk("rst_hold",   32'(a_if.o_hold), 32'd0);
      chk("rst_bubble", 32'(a_if.o_bubble), 32'd0);
      chk("rst_sel1",   32'(a_if.o_fwd_sel_op1), 32'd0);
      chk("rst_cnt",    32'(a_if.o_stall_cnt), 32'd0);
      rst = 1'b0;

      // add x5 then add x6,x5,x0: forward from EX
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive_a(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
      chk("alu_sel1",   32'(a_if.o_fwd_sel_op1), 32'd1);
      chk("alu_sel2",   32'(a_if.o_fwd_sel_op2), 32'd0);
      chk("alu_hold",   32'(a_if.o_hold), 32'd0);
      chk("alu_bubble", 32'(a_if.o_bubble), 32'd0);
      tick();

      // lw x6 then add x7,x6,x6: one bubble, then forward from MEM
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      chk("lw_issue_hold", 32'(a_if.o_hold), 32'd0);
      tick();
      drive_a(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
      chk("lu_hold",   32'(a_if.o_hold), 32'd1);
      chk("lu_bubble", 32'(a_if.o_bubble), 32'd1);
      tick();
      chk("lu_cnt",     32'(a_if.o_stall_cnt), 32'd1);
      chk("lu_sel1",    32'(a_if.o_fwd_sel_op1), 32'd2);
      chk("lu_sel2",    32'(a_if.o_fwd_sel_op2), 32'd2);
      chk("lu_hold2",   32'(a_if.o_hold), 32'd0);
      chk("lu_bubble2", 32'(a_if.o_bubble), 32'd0);
      tick();

      // x5 in e1 and e2: youngest wins; x0 never forwards
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive_a(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("young_sel1", 32'(a_if.o_fwd_sel_op1), 32'd1);
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      drive_a(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("x0_sel1",  32'(a_if.o_fwd_sel_op1), 32'd0);
      chk("mem_sel2", 32'(a_if.o_fwd_sel_op2), 32'd2);

      // x9 writer reaches WB: register file bypass covers it
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      tick();
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      tick();
      drive_a(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("wb_sel1", 32'(a_if.o_fwd_sel_op1), 32'd0);
      chk("wb_hold", 32'(a_if.o_hold), 32'd0);

      // downstream stall for 3 cycles with lw x6 in e1 and consumer in ID
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      tick();
      a_if.i_stall = 1'b1;
      drive_a(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("stl_hold",   32'(a_if.o_hold), 32'd1);
         chk("stl_bubble", 32'(a_if.o_bubble), 32'd0);
         chk("stl_cnt",    32'(a_if.o_stall_cnt), 32'd1);
         tick();
      end
      a_if.i_stall = 1'b0;
      #1;
      chk("rel_hold",   32'(a_if.o_hold), 32'd1);
      chk("rel_bubble", 32'(a_if.o_bubble), 32'd1);
      tick();
      chk("rel_cnt",  32'(a_if.o_stall_cnt), 32'd2);
      chk("rel_sel1", 32'(a_if.o_fwd_sel_op1), 32'd2);
      chk("rel_hold2", 32'(a_if.o_hold), 32'd0);
      tick();

      // flush of a load-use dependent: no hold, and its rd x8 never enters e1
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      tick();
      a_if.i_flush = 1'b1;
      drive_a(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      chk("fl_hold",   32'(a_if.o_hold), 32'd0);
      chk("fl_bubble", 32'(a_if.o_bubble), 32'd0);
      tick();
      a_if.i_flush = 1'b0;
      drive_a(1'b1, 5'd8, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("fl_e1_sel1", 32'(a_if.o_fwd_sel_op1), 32'd0);
      chk("fl_sel2",    32'(a_if.o_fwd_sel_op2), 32'd2);
      chk("fl_hold2",   32'(a_if.o_hold), 32'd0);
      chk("fl_cnt",     32'(a_if.o_stall_cnt), 32'd2);
      tick();

      // reset pulse during a load-use stall
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      tick();
      drive_a(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      chk("mr_hold_pre", 32'(a_if.o_hold), 32'd1);
      rst = 1'b1;
      #1;
      chk("mr_hold", 32'(a_if.o_hold), 32'd0);
      chk("mr_cnt",  32'(a_if.o_stall_cnt), 32'd0);
      rst = 1'b0;
      #1;
      chk("mr_hold_post", 32'(a_if.o_hold), 32'd0);
      tick();
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

      // B: load in e2 with LOAD_STAGE=3 holds one cycle, then sel=3; WB not bypassed
      drive_b(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      drive_b(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("b_e2_hold",   32'(b_if.o_hold), 32'd1);
      chk("b_e2_bubble", 32'(b_if.o_bubble), 32'd1);
      tick();
      chk("b_e3_sel1", 32'(b_if.o_fwd_sel_op1), 32'd3);
      chk("b_e3_hold", 32'(b_if.o_hold), 32'd0);
      chk("b_cnt1",    32'(b_if.o_stall_cnt), 32'd1);
      tick();
      drive_b(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("b_e4_sel2", 32'(b_if.o_fwd_sel_op2), 32'd4);
      tick();

      // B: load right ahead stalls two cycles; counter saturates at 3
      drive_b(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      drive_b(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("b_k1_hold1", 32'(b_if.o_hold), 32'd1);
      tick();
      chk("b_k1_hold2", 32'(b_if.o_hold), 32'd1);
      tick();
      chk("b_k1_sel1", 32'(b_if.o_fwd_sel_op1), 32'd3);
      chk("b_cnt3",    32'(b_if.o_stall_cnt), 32'd3);
      tick();
      drive_b(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      drive_b(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
      tick();
      tick();
      chk("b_sat_sel2", 32'(b_if.o_fwd_sel_op2), 32'd3);
      chk("b_sat_cnt",  32'(b_if.o_stall_cnt), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
